// File: rtl/mcp_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit.
package mcp_pkg;

  typedef enum logic [2:0] {
    ST_FETCH, ST_DECODE, ST_EXECUTE, ST_MEM, ST_WB, ST_TRAP
  } state_t;

  typedef enum logic [2:0] {
    CL_ALU, CL_LOAD, CL_STORE, CL_BRANCH, CL_JUMP
  } iclass_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SLL   = 4'b0101;
  localparam logic [3:0] ALU_SRL   = 4'b0110;
  localparam logic [3:0] ALU_SRA   = 4'b0111;
  localparam logic [3:0] ALU_SLT   = 4'b1000;
  localparam logic [3:0] ALU_SLTU  = 4'b1001;
  localparam logic [3:0] ALU_OR    = 4'b1010;
  localparam logic [3:0] ALU_AND   = 4'b1011;
  localparam logic [3:0] ALU_PASSB = 4'b1100;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] WB_MEM = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  typedef struct packed {
    logic [2:0] imm_sel;
    logic       a_sel;
    logic       b_sel;
    logic [3:0] alu_op;
    logic [1:0] wb_sel;
    iclass_t    cls;
    logic       illegal;
  } dec_t;

  // funct7[5] picks SUB only for register ops; it picks SRA for both forms.
  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt,
                                             input logic is_reg);
    logic [3:0] op;
    op = ALU_ADD;
    case (f3)
      3'b000:  op = (alt && is_reg) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mcp_decoder.sv
// Combinational instruction decoder: IR contents to control fields and class.
module mcp_decoder
  import mcp_pkg::*;
(
  input  logic [31:0] instr_i,
  output dec_t        dec_o
);

  logic [6:0] w_opcode;
  logic [2:0] w_f3;
  logic       w_alt;
  logic       w_unused;

  assign w_opcode = instr_i[6:0];
  assign w_f3     = instr_i[14:12];
  assign w_alt    = instr_i[30];
  assign w_unused = ^{instr_i[31], instr_i[29:15], instr_i[11:7]};

  always_comb begin
    dec_o.imm_sel = IMM_I;
    dec_o.a_sel   = 1'b0;
    dec_o.b_sel   = 1'b0;
    dec_o.alu_op  = ALU_ADD;
    dec_o.wb_sel  = WB_ALU;
    dec_o.cls     = CL_ALU;
    dec_o.illegal = 1'b0;
    case (w_opcode)
      OP_REG: dec_o.alu_op = alu_from_f3(w_f3, w_alt, 1'b1);
      OP_IMM: begin
        dec_o.b_sel  = 1'b1;
        dec_o.alu_op = alu_from_f3(w_f3, w_alt, 1'b0);
      end
      OP_LUI: begin
        dec_o.imm_sel = IMM_U;
        dec_o.b_sel   = 1'b1;
        dec_o.alu_op  = ALU_PASSB;
      end
      OP_AUIPC: begin
        dec_o.imm_sel = IMM_U;
        dec_o.a_sel   = 1'b1;
        dec_o.b_sel   = 1'b1;
      end
      OP_JAL: begin
        dec_o.imm_sel = IMM_J;
        dec_o.a_sel   = 1'b1;
        dec_o.b_sel   = 1'b1;
        dec_o.wb_sel  = WB_PC4;
        dec_o.cls     = CL_JUMP;
      end
      OP_JALR: begin
        dec_o.b_sel  = 1'b1;
        dec_o.wb_sel = WB_PC4;
        dec_o.cls    = CL_JUMP;
      end
      OP_BRANCH: begin
        dec_o.imm_sel = IMM_B;
        dec_o.a_sel   = 1'b1;
        dec_o.b_sel   = 1'b1;
        dec_o.cls     = CL_BRANCH;
        dec_o.illegal = (w_f3 == 3'b010) || (w_f3 == 3'b011);
      end
      OP_LOAD: begin
        dec_o.b_sel  = 1'b1;
        dec_o.wb_sel = WB_MEM;
        dec_o.cls    = CL_LOAD;
      end
      OP_STORE: begin
        dec_o.imm_sel = IMM_S;
        dec_o.b_sel   = 1'b1;
        dec_o.cls     = CL_STORE;
      end
      default: dec_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mcp_controller.sv
// Multi-cycle RV32I control FSM with memory handshake, trap and perf counters.
module mcp_controller
  import mcp_pkg::*;
#(
  parameter int unsigned X_LEN = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [X_LEN-1:0] instr_i,
  input  logic [X_LEN-1:0] rs1_data_i,
  input  logic [X_LEN-1:0] rs2_data_i,
  input  logic             mem_ready_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic             ADDR_SEL_o,
  output logic             IR_WE_o,
  output logic             PC_WE_o,
  output logic             PC_SEL_o,
  output logic [2:0]       IMM_SEL_o,
  output logic             REG_WRITE_o,
  output logic             A_SEL_o,
  output logic             B_SEL_o,
  output logic [3:0]       ALU_OP_o,
  output logic [1:0]       WB_SEL_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] cycle_o,
  output logic [CNT_W-1:0] instret_o
);

  state_t           r_state;
  logic             r_illegal;
  logic [CNT_W-1:0] r_cycle;
  logic [CNT_W-1:0] r_instret;
  dec_t             w_dec;
  logic             w_taken;
  logic             w_store;

  mcp_decoder u_decoder (
    .instr_i (instr_i[31:0]),
    .dec_o   (w_dec)
  );

  assign w_store = (w_dec.cls == CL_STORE);

  // Branch condition from funct3; 010/011 never reach EXECUTE.
  always_comb begin
    w_taken = 1'b0;
    case (instr_i[14:12])
      3'b000:  w_taken = (rs1_data_i == rs2_data_i);
      3'b001:  w_taken = (rs1_data_i != rs2_data_i);
      3'b100:  w_taken = ($signed(rs1_data_i) <  $signed(rs2_data_i));
      3'b101:  w_taken = ($signed(rs1_data_i) >= $signed(rs2_data_i));
      3'b110:  w_taken = (rs1_data_i <  rs2_data_i);
      3'b111:  w_taken = (rs1_data_i >= rs2_data_i);
      default: w_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= ST_FETCH;
      r_illegal <= 1'b0;
      r_cycle   <= '0;
      r_instret <= '0;
    end else begin
      r_cycle <= r_cycle + CNT_W'(1);
      if (PC_WE_o) r_instret <= r_instret + CNT_W'(1);
      case (r_state)
        ST_FETCH:  if (mem_ready_i) r_state <= ST_DECODE;
        ST_DECODE: begin
          if (w_dec.illegal) begin
            r_state   <= ST_TRAP;
            r_illegal <= 1'b1;
          end else begin
            r_state <= ST_EXECUTE;
          end
        end
        ST_EXECUTE: begin
          case (w_dec.cls)
            CL_BRANCH:         r_state <= ST_FETCH;
            CL_LOAD, CL_STORE: r_state <= ST_MEM;
            default:           r_state <= ST_WB;
          endcase
        end
        ST_MEM:  if (mem_ready_i) r_state <= w_store ? ST_FETCH : ST_WB;
        ST_WB:   r_state <= ST_FETCH;
        ST_TRAP: r_state <= ST_TRAP;
        default: r_state <= ST_FETCH;
      endcase
    end
  end

  // Strobes decode from state; everything is forced low while reset is held.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    ADDR_SEL_o  = 1'b0;
    IR_WE_o     = 1'b0;
    PC_WE_o     = 1'b0;
    PC_SEL_o    = 1'b0;
    REG_WRITE_o = 1'b0;
    IMM_SEL_o   = IMM_I;
    A_SEL_o     = 1'b0;
    B_SEL_o     = 1'b0;
    ALU_OP_o    = ALU_ADD;
    WB_SEL_o    = WB_MEM;
    if (!rst_i && (r_state inside {ST_DECODE, ST_EXECUTE, ST_MEM, ST_WB})) begin
      IMM_SEL_o = w_dec.imm_sel;
      A_SEL_o   = w_dec.a_sel;
      B_SEL_o   = w_dec.b_sel;
      ALU_OP_o  = w_dec.alu_op;
      WB_SEL_o  = w_dec.wb_sel;
    end
    if (!rst_i) begin
      case (r_state)
        ST_FETCH: begin
          mem_req_o = 1'b1;
          IR_WE_o   = mem_ready_i;
        end
        ST_EXECUTE: begin
          if (w_dec.cls == CL_BRANCH) begin
            PC_WE_o  = 1'b1;
            PC_SEL_o = w_taken;
          end
        end
        ST_MEM: begin
          mem_req_o  = 1'b1;
          ADDR_SEL_o = 1'b1;
          mem_we_o   = w_store;
          PC_WE_o    = w_store && mem_ready_i;
        end
        ST_WB: begin
          REG_WRITE_o = 1'b1;
          PC_WE_o     = 1'b1;
          PC_SEL_o    = (w_dec.cls == CL_JUMP);
        end
        default: ;
      endcase
    end
  end

  assign illegal_o = r_illegal;
  assign cycle_o   = r_cycle;
  assign instret_o = r_instret;

endmodule

// File: doc/mcp_controller.md
Name: mcp_controller

Overview:
- Multi-cycle successor to the single-cycle control unit.
- A state machine sequences each RV32I instruction through FETCH/DECODE/EXECUTE/MEM/WB.
- Talks to a shared instruction/data memory through a req/ready handshake, so wait states are tolerated.
- Adds illegal-instruction trapping, a LUI pass-through ALU op, and free-running cycle/instret counters.
- Sits between the datapath (PC, IR, register file, ALU, memory port) and the memory interface.

Parameters:
- X_LEN, 32, datapath width of rs1/rs2 compare operands and instruction.
- CNT_W, 32, width of cycle and instret counters.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- instr_i  in  X_LEN  IR contents; stable from DECODE until the instruction ends
- rs1_data_i  in  X_LEN  register file read port 1
- rs2_data_i  in  X_LEN  register file read port 2
- mem_ready_i  in  1  memory completes the current request this cycle
- mem_req_o  out  1  memory request valid
- mem_we_o  out  1  request is a store
- ADDR_SEL_o  out  1  0 = PC drives memory address, 1 = ALU result
- IR_WE_o  out  1  load IR from memory read data
- PC_WE_o  out  1  update PC this cycle
- PC_SEL_o  out  1  0 = PC+4, 1 = ALU target
- IMM_SEL_o  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- REG_WRITE_o  out  1  register file write enable
- A_SEL_o  out  1  0 = rs1, 1 = PC
- B_SEL_o  out  1  0 = rs2, 1 = immediate
- ALU_OP_o  out  4  ADD 0000, SUB 0001, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001, OR 1010, AND 1011, PASSB 1100
- WB_SEL_o  out  2  00 mem, 01 ALU, 10 PC+4
- illegal_o  out  1  sticky trap flag
- cycle_o  out  CNT_W  cycle counter
- instret_o  out  CNT_W  retired-instruction counter

Behaviour:
- Reset state and outputs:
  - State FETCH; counters 0; illegal_o 0.
  - All strobes (mem_req_o, mem_we_o, IR_WE_o, PC_WE_o, REG_WRITE_o) are 0 outside the states listed below.
  - A reset mid-instruction aborts it with no PC or register write.
- FETCH:
  - mem_req_o=1, ADDR_SEL_o=0; hold until mem_ready_i.
  - The ready cycle asserts IR_WE_o=1, then -> DECODE. Ready must be seen in the same cycle; no req drop while waiting.
- DECODE:
  - Decode fields (IMM_SEL_o, A/B_SEL_o, ALU_OP_o, WB_SEL_o) become valid and are held through the instruction end.
  - Unknown opcode, or an unsupported funct3 for a branch, -> TRAP. Otherwise -> EXECUTE.
- EXECUTE, by instruction class:
  - Branch: A_SEL=1, B_SEL=1, IMM_SEL=B, ALU ADD. Compare per funct3 (EQ, NE, signed LT/GE, unsigned LTU/GEU). PC_WE_o=1, PC_SEL_o=taken. Retire, -> FETCH.
  - Load/store: ALU ADD, B_SEL=1 (IMM_SEL=S for store). -> MEM.
  - R/I-type ALU, LUI, AUIPC, JAL, JALR: -> WB.
- MEM:
  - mem_req_o=1, ADDR_SEL_o=1, mem_we_o=store.
  - Wait for mem_ready_i. Load -> WB. Store: PC_WE_o=1, PC_SEL_o=0, retire, -> FETCH.
- WB (single cycle): REG_WRITE_o=1 and PC_WE_o=1, then retire and -> FETCH.
  - Load: WB_SEL=00.
  - ALU/LUI/AUIPC: WB_SEL=01, PC_SEL=0.
  - JAL/JALR: WB_SEL=10, PC_SEL=1.
- Per-instruction decode details:
  - LUI: ALU_OP=PASSB, IMM_SEL=U.
  - AUIPC: A_SEL=1, ADD, IMM_SEL=U.
  - JAL: A_SEL=1, IMM_SEL=J.
  - JALR: A_SEL=0, IMM_SEL=I.
  - funct7[5] selects SUB only for R-type, and SRA for both R-type and I-type shifts.
- TRAP: absorbing state. illegal_o=1, no strobes. Leaves only on reset.
- Counters:
  - cycle_o increments every cycle after reset, including TRAP.
  - instret_o increments on each retire, i.e. the cycle PC_WE_o=1.
  - Both wrap modulo 2^CNT_W.
- Timing:
  - Zero-wait latencies: ALU/jump 4 cycles, branch 3, store 4, load 5.
  - Each mem_ready_i low cycle adds one cycle.

Decomposition:
- mcp_pkg holds:
  - state enum;
  - opcode constants;
  - ALU_OP, IMM_SEL and WB_SEL localparams;
  - a decode struct (imm_sel, a_sel, b_sel, alu_op, wb_sel, class, illegal).
- Sub-module mcp_decoder: purely combinational, mapping instr_i to the decode struct.
- The FSM, branch compare and counters live in mcp_controller.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), mem_ready_i always 1 -> IR_WE in cycle 1, REG_WRITE_o=1 with ALU_OP=0000, WB_SEL=01 in cycle 4; instret_o=1 after.
- LW (0x0000A183) with mem_ready_i low for 3 cycles in MEM -> mem_req_o held 4 cycles with ADDR_SEL_o=1; WB_SEL=00 write in cycle 8.
- BEQ (0x00208463), rs1=rs2=5 -> PC_WE_o=1, PC_SEL_o=1 in cycle 3. Repeat with rs2=6 -> PC_SEL_o=0.
- BLT with rs1=0xFFFFFFFF, rs2=1 -> taken. BLTU with the same operands -> not taken.
- Opcode 0x0000007F -> illegal_o=1 from cycle 3; no further mem_req_o; cycle_o keeps counting; rst_i pulse clears it.
- rst_i asserted mid-MEM of a store -> outputs 0 asynchronously, mem_we_o never completes, FETCH restarts, counters 0.
